// File: rtl/counter_ctl_if.sv
// counter_ctl_if: command/status bundle between a controlling FSM and counter_ctl.
//   master modport (FSM side):     drives cmd_i, mode_i, vmax_i, load_i;
//                                  observes count_o, flag_o, zero_o, bound_o.
//   slave modport  (counter side): the reverse.
// Signal names keep the counter's point of view, so the _i/_o suffixes read
// as seen from the counter on both modports.
interface counter_ctl_if #(
  parameter int unsigned Width = 4
);
  logic [2:0]       cmd_i;    // command code, applied on every edge
  logic             mode_i;   // 0 = wrap, 1 = saturate at both bounds
  logic [Width-1:0] vmax_i;   // terminal (upper bound) value
  logic [Width-1:0] load_i;   // value loaded by the load command
  logic [Width-1:0] count_o;  // registered count
  logic             flag_o;   // count_o == vmax_i
  logic             zero_o;   // count_o == 0
  logic             bound_o;  // one-cycle pulse after a bound event

  modport master (
    output cmd_i, mode_i, vmax_i, load_i,
    input  count_o, flag_o, zero_o, bound_o
  );

  modport slave (
    input  cmd_i, mode_i, vmax_i, load_i,
    output count_o, flag_o, zero_o, bound_o
  );
endinterface

// File: rtl/counter_ctl.sv
// counter_ctl: up/down event counter with command-coded control, programmable
// terminal value and selectable wrap/saturate behaviour at both bounds.
// Ports:
//   clk_i  - system clock, all state updates on the rising edge
//   rst_i  - synchronous active-high reset, overrides any command
//   bus    - counter_ctl_if slave modport: cmd_i, mode_i, vmax_i, load_i in;
//            count_o (registered), flag_o/zero_o (combinational),
//            bound_o (registered pulse) out
module counter_ctl #(
  parameter int unsigned Width = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  counter_ctl_if.slave bus
);

  typedef enum logic [2:0] {
    CmdHold    = 3'b000,
    CmdClear   = 3'b001,
    CmdInc     = 3'b010,
    CmdDec     = 3'b011,
    CmdLoad    = 3'b100,
    CmdLoadMax = 3'b101
  } cmd_e;

  logic [Width-1:0] count_q, count_d;
  logic             bound_q, bound_d;

  always_comb begin
    count_d = count_q;
    bound_d = 1'b0;
    case (bus.cmd_i)
      CmdClear: count_d = '0;
      CmdInc: begin
        // A count above vmax_i is treated as at the bound, so +1 never overflows.
        if (count_q < bus.vmax_i) begin
          count_d = count_q + Width'(1);
        end else begin
          bound_d = 1'b1;
          count_d = bus.mode_i ? bus.vmax_i : '0;
        end
      end
      CmdDec: begin
        // Counts above vmax_i still step down normally.
        if (count_q != '0) begin
          count_d = count_q - Width'(1);
        end else begin
          bound_d = 1'b1;
          count_d = bus.mode_i ? '0 : bus.vmax_i;
        end
      end
      CmdLoad:    count_d = bus.load_i;
      CmdLoadMax: count_d = bus.vmax_i;
      default:    ;  // hold and reserved codes
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      bound_q <= 1'b0;
    end else begin
      count_q <= count_d;
      bound_q <= bound_d;
    end
  end

  assign bus.count_o = count_q;
  assign bus.bound_o = bound_q;
  assign bus.flag_o  = (count_q == bus.vmax_i);
  assign bus.zero_o  = (count_q == '0);

endmodule
